// File: rtl/hazard_ctrl_pkg.sv
// Core-wide pipeline constants and hazard controller FSM encoding.
// Shared by the hazard controller and the forwarding unit.
package hazard_ctrl_pkg;

  localparam int CORE_REG_IDX_W = 4;
  localparam int CORE_MEM_WAIT  = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_load_use_cmp.sv
// Load-use comparator: flags an ID source that reads the
// destination of a load currently in EX.
module load_use_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = CORE_REG_IDX_W
) (
  input  logic                 i_load,
  input  logic [REG_IDX_W-1:0] i_wr_idx,
  input  logic [REG_IDX_W-1:0] i_rd_idx1,
  input  logic [REG_IDX_W-1:0] i_rd_idx2,
  input  logic                 i_rd_en1,
  input  logic                 i_rd_en2,
  output logic                 o_hazard
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1   = i_rd_en1 && (i_rd_idx1 == i_wr_idx);
  assign w_hit2   = i_rd_en2 && (i_rd_idx2 == i_wr_idx);
  assign o_hazard = i_load && (w_hit1 || w_hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch flush and
// shared-RAM arbitration with a saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT  = CORE_MEM_WAIT,
  parameter int REG_IDX_W = CORE_REG_IDX_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 MemReqMem,
  input  logic                 LoadEx,
  input  logic [REG_IDX_W-1:0] WrIdxEx,
  input  logic [REG_IDX_W-1:0] RdIdx1Id,
  input  logic [REG_IDX_W-1:0] RdIdx2Id,
  input  logic                 RdEn1Id,
  input  logic                 RdEn2Id,
  input  logic                 BranchTakenEx,
  output logic                 PcWe,
  output logic                 IfIdWe,
  output logic                 IdExWe,
  output logic                 ExMemWe,
  output logic                 IfIdFlush,
  output logic                 IdExFlush,
  output logic                 MemWbFlush,
  output logic                 RamSelMem,
  output logic [15:0]          StallCycles
);

  localparam logic [1:0] LP_CNT_INIT =
    (MEM_WAIT > 1) ? 2'(MEM_WAIT - 2) : 2'd0;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_wait_cnt;
  logic [1:0]  w_wait_nxt;
  logic [15:0] r_stall;
  logic        w_access;
  logic        w_last;
  logic        w_busy;
  logic        w_lu;

  load_use_cmp #(
    .REG_IDX_W (REG_IDX_W)
  ) u_lu_cmp (
    .i_load    (LoadEx),
    .i_wr_idx  (WrIdxEx),
    .i_rd_idx1 (RdIdx1Id),
    .i_rd_idx2 (RdIdx2Id),
    .i_rd_en1  (RdEn1Id),
    .i_rd_en2  (RdEn2Id),
    .o_hazard  (w_lu)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (MemReqMem && (MEM_WAIT > 1)) begin
          w_state_nxt = ST_ACCESS;
          w_wait_nxt  = LP_CNT_INIT;
        end
      end
      ST_ACCESS: begin
        if (r_wait_cnt == 2'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt - 2'd1;
        end
      end
      default: ;
    endcase
  end

  // The IDLE cycle that sees a request is already the first access cycle.
  assign w_access = (r_state == ST_ACCESS) || MemReqMem;
  assign w_last   = (r_state == ST_ACCESS) ? (r_wait_cnt == 2'd0)
                                           : (MemReqMem && (MEM_WAIT == 1));
  assign w_busy   = w_access && !w_last;

  always_comb begin
    PcWe       = 1'b1;
    IfIdWe     = 1'b1;
    IdExWe     = 1'b1;
    ExMemWe    = 1'b1;
    IfIdFlush  = 1'b0;
    IdExFlush  = 1'b0;
    MemWbFlush = 1'b0;
    RamSelMem  = w_access;
    if (Rst) begin
      PcWe       = 1'b0;
      IfIdWe     = 1'b0;
      IdExWe     = 1'b0;
      ExMemWe    = 1'b0;
      IfIdFlush  = 1'b1;
      IdExFlush  = 1'b1;
      MemWbFlush = 1'b1;
      RamSelMem  = 1'b0;
    end else if (w_busy) begin
      PcWe       = 1'b0;
      IfIdWe     = 1'b0;
      IdExWe     = 1'b0;
      ExMemWe    = 1'b0;
      MemWbFlush = 1'b1;
    end else if (BranchTakenEx) begin
      IfIdFlush = 1'b1;
      IdExFlush = 1'b1;
    end else if (w_lu) begin
      PcWe      = 1'b0;
      IfIdWe    = 1'b0;
      IdExFlush = 1'b1;
    end else if (w_access) begin
      PcWe      = 1'b0;
      IfIdFlush = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall <= 16'd0;
    end else if (!PcWe && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign StallCycles = r_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl, run with MEM_WAIT=1 and
// MEM_WAIT=3 instances sharing one stimulus stream.
module tb_hazard_ctrl;

  typedef struct {
    logic [7:0]  v[2];
    logic [15:0] s[2];
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       MemReqMem;
  logic       LoadEx;
  logic [3:0] WrIdxEx;
  logic [3:0] RdIdx1Id;
  logic [3:0] RdIdx2Id;
  logic       RdEn1Id;
  logic       RdEn2Id;
  logic       BranchTakenEx;

  logic        PcWe1, IfIdWe1, IdExWe1, ExMemWe1;
  logic        IfIdFl1, IdExFl1, MemWbFl1, RamSel1;
  logic [15:0] Stall1;
  logic        PcWe3, IfIdWe3, IdExWe3, ExMemWe3;
  logic        IfIdFl3, IdExFl3, MemWbFl3, RamSel3;
  logic [15:0] Stall3;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  int   mdl_pos[2];
  logic [15:0] mdl_stall[2];

  always #5 Clk = ~Clk;

  hazard_ctrl #(.MEM_WAIT(1), .REG_IDX_W(4)) u_dut1 (
    .Clk (Clk), .Rst (Rst), .MemReqMem (MemReqMem),
    .LoadEx (LoadEx), .WrIdxEx (WrIdxEx),
    .RdIdx1Id (RdIdx1Id), .RdIdx2Id (RdIdx2Id),
    .RdEn1Id (RdEn1Id), .RdEn2Id (RdEn2Id),
    .BranchTakenEx (BranchTakenEx),
    .PcWe (PcWe1), .IfIdWe (IfIdWe1), .IdExWe (IdExWe1),
    .ExMemWe (ExMemWe1), .IfIdFlush (IfIdFl1),
    .IdExFlush (IdExFl1), .MemWbFlush (MemWbFl1),
    .RamSelMem (RamSel1), .StallCycles (Stall1)
  );

  hazard_ctrl #(.MEM_WAIT(3), .REG_IDX_W(4)) u_dut3 (
    .Clk (Clk), .Rst (Rst), .MemReqMem (MemReqMem),
    .LoadEx (LoadEx), .WrIdxEx (WrIdxEx),
    .RdIdx1Id (RdIdx1Id), .RdIdx2Id (RdIdx2Id),
    .RdEn1Id (RdEn1Id), .RdEn2Id (RdEn2Id),
    .BranchTakenEx (BranchTakenEx),
    .PcWe (PcWe3), .IfIdWe (IfIdWe3), .IdExWe (IdExWe3),
    .ExMemWe (ExMemWe3), .IfIdFlush (IfIdFl3),
    .IdExFlush (IdExFl3), .MemWbFlush (MemWbFl3),
    .RamSelMem (RamSel3), .StallCycles (Stall3)
  );

  task automatic chk_eq(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Vector order: PcWe IfIdWe IdExWe ExMemWe IfIdFl IdExFl MemWbFl RamSel
  task automatic step(input logic rst, input logic req,
                      input logic ld, input logic [3:0] wr,
                      input logic [3:0] r1, input logic [3:0] r2,
                      input logic e1, input logic e2,
                      input logic br, input bit chk);
    exp_t e;
    exp_t o;
    logic hz;
    @(negedge Clk);
    Rst = rst; MemReqMem = req; LoadEx = ld; WrIdxEx = wr;
    RdIdx1Id = r1; RdIdx2Id = r2; RdEn1Id = e1; RdEn2Id = e2;
    BranchTakenEx = br;
    hz = ld && ((e1 && r1 == wr) || (e2 && r2 == wr));
    for (int i = 0; i < 2; i++) begin
      int   w;
      int   cur;
      logic in_acc;
      logic last;
      logic [7:0] vec;
      w      = (i == 0) ? 1 : 3;
      in_acc = (mdl_pos[i] > 0) || req;
      cur    = mdl_pos[i] + 1;
      last   = in_acc && (cur == w);
      vec    = {7'b1111000, in_acc};
      if (rst)                  vec = 8'b0000_1110;
      else if (in_acc && !last) vec = 8'b0000_0011;
      else if (br)              vec = {6'b1111_11, 1'b0, in_acc};
      else if (hz)              vec = {6'b0011_01, 1'b0, in_acc};
      else if (in_acc)          vec = 8'b0111_1001;
      e.v[i] = vec;
      e.s[i] = mdl_stall[i];
      if (rst) mdl_stall[i] = 16'd0;
      else if (!vec[7] && mdl_stall[i] != 16'hFFFF)
        mdl_stall[i] = mdl_stall[i] + 16'd1;
      if (rst)                  mdl_pos[i] = 0;
      else if (in_acc && !last) mdl_pos[i] = cur;
      else                      mdl_pos[i] = 0;
    end
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    if (chk) begin
      chk_eq("ctl_w1", {24'd0, PcWe1, IfIdWe1, IdExWe1, ExMemWe1,
             IfIdFl1, IdExFl1, MemWbFl1, RamSel1}, {24'd0, o.v[0]});
      chk_eq("stall_w1", {16'd0, Stall1}, {16'd0, o.s[0]});
      chk_eq("ctl_w3", {24'd0, PcWe3, IfIdWe3, IdExWe3, ExMemWe3,
             IfIdFl3, IdExFl3, MemWbFl3, RamSel3}, {24'd0, o.v[1]});
      chk_eq("stall_w3", {16'd0, Stall3}, {16'd0, o.s[1]});
    end
  endtask

  initial begin
    mdl_pos   = '{0, 0};
    mdl_stall = '{16'd0, 16'd0};
    // reset, first cycle unchecked since counters start unknown
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // load-use on port 1, then disabled read, then port 2
    step(0, 0, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 1);
    step(0, 0, 0, 4'd3, 4'd3, 4'd0, 1, 0, 0, 1);
    step(0, 0, 1, 4'd3, 4'd3, 4'd0, 0, 0, 0, 1);
    step(0, 0, 1, 4'd5, 4'd1, 4'd5, 1, 1, 0, 1);
    // branch overrides load-use
    step(0, 0, 1, 4'd3, 4'd3, 4'd0, 1, 0, 1, 1);
    step(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);
    // single-cycle request; W=3 instance completes on its own
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // back-to-back accesses with request held
    repeat (6) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset in access cycle 2
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // branch deferred through access
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // load-use in last access cycle holds IF/ID
    repeat (3) step(0, 1, 1, 4'd2, 4'd2, 4'd0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // random mix
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 1);
    end
    // saturation
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 32'h10005; k++)
      step(0, 0, 1, 4'd7, 4'd7, 4'd0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 4'd7, 4'd7, 4'd0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
